button_debouncer: RTL and testbench

//   Cleans one raw mechanical push-button input: 2-FF synchronizer, counter-based debounce filter,

---
 rtl/button_debouncer.sv | 146 ++++++++++++++
 tb/tb_button_debouncer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, counter debounce filter and a
// hold/auto-repeat state machine producing long-press and repeat strobes.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high; clears all state and outputs
//   button_raw   : raw asynchronous pin, may bounce
//   button_level : debounced level, 1 = pressed (polarity normalised)
//   long_press   : one-cycle strobe when the hold threshold is reached
//   repeat_pulse : one-cycle strobe every REPEAT_CYCLES while held past threshold
//   hold_active  : 1 from long_press until the release is seen
module button_debouncer #(
    parameter bit          INVERT          = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic button_level,
    output logic long_press,
    output logic repeat_pulse,
    output logic hold_active
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned RPT_W  = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    // The IDLE->PRESSED edge consumes one hold cycle, so PRESSED counts to HOLD-2.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_e;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              long_press_q, long_press_d;
    logic              repeat_pulse_q, repeat_pulse_d;
    logic              hold_active_q, hold_active_d;

    // Synchronizer and debounce filter: any cycle agreeing with the current
    // level restarts the stability count.
    always_comb begin
        sync1_d  = button_raw ^ INVERT;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Hold / auto-repeat state machine; acts on the registered debounced level.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        rpt_cnt_d      = rpt_cnt_q;
        long_press_d   = 1'b0;
        repeat_pulse_d = 1'b0;
        hold_active_d  = hold_active_q;
        case (state_q)
            ST_IDLE: begin
                hold_active_d = 1'b0;
                if (level_q) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_press_d  = 1'b1;
                    hold_active_d = 1'b1;
                    rpt_cnt_d     = '0;
                    state_d       = ST_REPEAT;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!level_q) begin
                    state_d       = ST_IDLE;
                    hold_active_d = 1'b0;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    repeat_pulse_d = 1'b1;
                    rpt_cnt_d      = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                hold_active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            level_q        <= 1'b0;
            db_cnt_q       <= '0;
            state_q        <= ST_IDLE;
            hold_cnt_q     <= '0;
            rpt_cnt_q      <= '0;
            long_press_q   <= 1'b0;
            repeat_pulse_q <= 1'b0;
            hold_active_q  <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            level_q        <= level_d;
            db_cnt_q       <= db_cnt_d;
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            rpt_cnt_q      <= rpt_cnt_d;
            long_press_q   <= long_press_d;
            repeat_pulse_q <= repeat_pulse_d;
            hold_active_q  <= hold_active_d;
        end
    end

    assign button_level = level_q;
    assign long_press   = long_press_q;
    assign repeat_pulse = repeat_pulse_q;
    assign hold_active  = hold_active_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer with a history-based reference model.
module tb_button_debouncer;

    localparam bit          INVERT = 1'b1;
    localparam int unsigned DEB    = 4;
    localparam int unsigned HOLD   = 10;
    localparam int unsigned RPT    = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic button_raw = 1'b1;
    logic button_level, long_press, repeat_pulse, hold_active;

    int total = 0;
    int bad   = 0;

    // reference model state
    int n;          // edges since reset release
    bit raw_hist[$];// normalised raw value sampled at each edge
    bit s2_hist[$]; // synchronised value seen by the filter at each edge
    bit m_lvl;
    int m_rise;     // edge at which the level last rose, -1 if none
    bit e_lvl, e_lp, e_rp, e_ha;

    button_debouncer #(
        .INVERT(INVERT),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .button_raw(button_raw),
        .button_level(button_level),
        .long_press(long_press),
        .repeat_pulse(repeat_pulse),
        .hold_active(hold_active)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input bit got, input bit exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        n = 0;
        raw_hist.delete();
        s2_hist.delete();
        m_lvl  = 1'b0;
        m_rise = -1;
        e_lvl = 1'b0; e_lp = 1'b0; e_rp = 1'b0; e_ha = 1'b0;
    endfunction

    // One rising edge: the level flips once the last DEB synchronised samples
    // all disagree with it; strobes follow from the age of the current press.
    function automatic void m_edge(input bit r);
        bit s2;
        bit all_diff;
        int age;
        n++;
        s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
        raw_hist.push_back(r ^ INVERT);
        s2_hist.push_back(s2);
        age  = n - m_rise;
        e_lp = m_lvl && (age == HOLD);
        e_rp = m_lvl && (age > HOLD) && (((age - HOLD) % RPT) == 0);
        e_ha = m_lvl && (age >= HOLD);
        all_diff = (s2_hist.size() >= DEB);
        for (int i = 0; i < DEB && all_diff; i++)
            if (s2_hist[s2_hist.size()-1-i] == m_lvl) all_diff = 1'b0;
        if (all_diff) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_rise = n;
        end
        e_lvl = m_lvl;
    endfunction

    // Drive raw for one cycle, then compare all outputs against the model.
    task automatic step(input bit r);
        button_raw = r;
        @(posedge clock);
        m_edge(r);
        @(negedge clock);
        check_bit("level", button_level, e_lvl);
        check_bit("long_press", long_press, e_lp);
        check_bit("repeat_pulse", repeat_pulse, e_rp);
        check_bit("hold_active", hold_active, e_ha);
    endtask

    // Assert reset between edges and check everything clears before the next edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        check_bit({tag, "_level"}, button_level, 1'b0);
        check_bit({tag, "_long_press"}, long_press, 1'b0);
        check_bit({tag, "_repeat_pulse"}, repeat_pulse, 1'b0);
        check_bit({tag, "_hold_active"}, hold_active, 1'b0);
        m_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bit r;
        int len;
        m_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_bit("rst_level", button_level, 1'b0);
        check_bit("rst_long_press", long_press, 1'b0);
        check_bit("rst_repeat_pulse", repeat_pulse, 1'b0);
        check_bit("rst_hold_active", hold_active, 1'b0);
        repeat (3) step(1'b1);

        // clean press: level at edge 6, long_press at E+10, repeats at E+13/16/19
        for (int i = 1; i <= 6; i++) begin
            step(1'b0);
            if (i == 5) check_bit("press_lvl_e5", button_level, 1'b0);
            if (i == 6) check_bit("press_lvl_e6", button_level, 1'b1);
        end
        for (int j = 1; j <= 20; j++) begin
            step(1'b0);
            if (j == 9)  check_bit("press_ha_e9", hold_active, 1'b0);
            if (j == 10) check_bit("press_lp_e10", long_press, 1'b1);
            if (j == 10) check_bit("press_ha_e10", hold_active, 1'b1);
            if (j == 13 || j == 16 || j == 19) check_bit("press_rp", repeat_pulse, 1'b1);
        end
        // reset while hold is active
        async_reset("arst");

        // held through reset: re-accepted, reset again at E+5, then re-accepted again
        repeat (11) step(1'b0);
        async_reset("arst_e5");
        for (int i = 1; i <= 30; i++) begin
            step(1'b0);
            if (i == 6)  check_bit("repress_lvl", button_level, 1'b1);
            if (i == 16) check_bit("repress_lp", long_press, 1'b1);
        end
        repeat (10) step(1'b1);

        // bounce with runs of 1..3 cycles ending high, then a clean press
        r = 1'b0;
        for (int c = 0; c < 40; c += len) begin
            len = $urandom_range(1, 3);
            repeat (len) step(r);
            r = !r;
        end
        repeat (2) step(1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0);
            if (i == 5) check_bit("bounce_lvl_e5", button_level, 1'b0);
            if (i == 6) check_bit("bounce_lvl_e6", button_level, 1'b1);
        end
        repeat (10) step(1'b1);

        // short press: level high for 8 cycles, no strobes
        repeat (8) step(1'b0);
        repeat (12) step(1'b1);

        // release in REPEAT at E+14
        repeat (6 + 9) step(1'b0);
        repeat (15) step(1'b1);

        // random presses with glitches and occasional mid-press resets
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
                if (i == len / 2 && $urandom_range(0, 7) == 0) async_reset("rnd_rst");
            end
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
